// File: rtl/vga_frame_reader_if.sv
// Read port of the scaler output RAM as seen by the VGA frame reader.
// The master issues addresses; the slave returns the data one clock later.
interface vga_frame_reader_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] rdaddr;
  logic [7:0]        q;

  modport master (output rdaddr, input q);
  modport slave  (input rdaddr, output q);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator that scans a centred grayscale image out of the scaler RAM.
// Geometry and validity are frozen at (0,0) so a frame never tears.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          img_width_i,
  input  logic [8:0]          img_height_i,
  input  logic                frame_valid_i,
  vga_frame_reader_if.master  ram,
  output logic                vga_hs_o,
  output logic                vga_vs_o,
  output logic                vga_blank_n_o,
  output logic                vga_sync_n_o,
  output logic [7:0]          vga_r_o,
  output logic [7:0]          vga_g_o,
  output logic [7:0]          vga_b_o,
  output logic                frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef logic [11:0] coord_t;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [9:0]        w_l_q;
  logic [8:0]        h_l_q;
  logic              show_q;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic              hs1_q, vs1_q, blank1_q, win1_q;
  logic              hs2_q, vs2_q, blank2_q, win2_q;

  logic              fs;
  logic [9:0]        cur_w;
  logic [8:0]        cur_h;
  logic              geom_ok;
  logic              cur_show;
  logic [ADDR_W-1:0] cur_rptr;
  coord_t            hx, vy, x_off, y_off;
  logic              win, hs0, vs0, blank0;

  // On the latch cycle the new frame's geometry is already in force, so the
  // window at (0,0) is judged with the incoming values rather than stale ones.
  always_comb begin
    fs       = (h_q == '0) && (v_q == '0);
    cur_w    = fs ? img_width_i  : w_l_q;
    cur_h    = fs ? img_height_i : h_l_q;
    geom_ok  = (cur_w != '0) && (coord_t'(cur_w) <= coord_t'(H_ACTIVE)) &&
               (cur_h != '0) && (coord_t'(cur_h) <= coord_t'(V_ACTIVE));
    cur_show = fs ? (frame_valid_i && geom_ok) : show_q;
    cur_rptr = fs ? '0 : rptr_q;
    hx       = coord_t'(h_q);
    vy       = coord_t'(v_q);
    x_off    = (coord_t'(H_ACTIVE) - coord_t'(cur_w)) >> 1;
    y_off    = (coord_t'(V_ACTIVE) - coord_t'(cur_h)) >> 1;
    win      = cur_show &&
               (hx >= x_off) && (hx < x_off + coord_t'(cur_w)) &&
               (vy >= y_off) && (vy < y_off + coord_t'(cur_h));
    hs0      = !((hx >= coord_t'(H_ACTIVE + H_FP)) &&
                 (hx <  coord_t'(H_ACTIVE + H_FP + H_SYNC)));
    vs0      = !((vy >= coord_t'(V_ACTIVE + V_FP)) &&
                 (vy <  coord_t'(V_ACTIVE + V_FP + V_SYNC)));
    blank0   = (hx < coord_t'(H_ACTIVE)) && (vy < coord_t'(V_ACTIVE));

    // Sequential addressing replaces a row*width multiply.
    rptr_d   = win ? cur_rptr + ADDR_W'(1) : cur_rptr;
    rdaddr_d = win ? cur_rptr : rdaddr_q;

    h_d = h_q;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      w_l_q    <= '0;
      h_l_q    <= '0;
      show_q   <= 1'b0;
      rptr_q   <= '0;
      rdaddr_q <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      win1_q   <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      win2_q   <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      rptr_q   <= rptr_d;
      rdaddr_q <= rdaddr_d;
      if (fs) begin
        w_l_q  <= img_width_i;
        h_l_q  <= img_height_i;
        show_q <= cur_show;
      end
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      blank1_q <= blank0;
      win1_q   <= win;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= blank1_q;
      win2_q   <= win1_q;
    end
  end

  // The RAM's own output register forms the second pipeline stage.
  assign ram.rdaddr    = rdaddr_q;
  assign vga_hs_o      = hs2_q;
  assign vga_vs_o      = vs2_q;
  assign vga_blank_n_o = blank2_q;
  assign vga_sync_n_o  = 1'b0;
  assign vga_r_o       = win2_q ? ram.q : 8'h00;
  assign vga_g_o       = win2_q ? ram.q : 8'h00;
  assign vga_b_o       = win2_q ? ram.q : 8'h00;
  assign frame_start_o = fs && rst_n;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader using a reduced timing mode so that
// many frames fit in a short run; expectations come from frame/pixel arithmetic.
module tb_vga_frame_reader;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  img_w;
  logic [8:0]  img_h;
  logic        fv;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_frame_reader_if #(.ADDR_W(19)) ram_bus ();

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .ADDR_W(19)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .img_width_i  (img_w),
    .img_height_i (img_h),
    .frame_valid_i(fv),
    .ram          (ram_bus),
    .vga_hs_o     (vga_hs),
    .vga_vs_o     (vga_vs),
    .vga_blank_n_o(vga_blank_n),
    .vga_sync_n_o (vga_sync_n),
    .vga_r_o      (vga_r),
    .vga_g_o      (vga_g),
    .vga_b_o      (vga_b),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_data(input logic [18:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Synchronous-read RAM whose contents are a function of the address.
  always @(posedge clk) ram_bus.q <= ram_data(ram_bus.rdaddr);

  int          g_w    [64];
  int          g_h    [64];
  bit          g_show [64];
  int          t;
  int          pass_cnt;
  int          total_cnt;
  logic [18:0] exp_rd;

  function automatic bit win_at(input int p, output int addr);
    int f, hp, vp, w, hh, xo, yo;
    f    = p / FT;
    hp   = p % HT;
    vp   = (p / HT) % VT;
    w    = g_w[f];
    hh   = g_h[f];
    addr = 0;
    if (!g_show[f]) return 1'b0;
    xo = (HA - w) / 2;
    yo = (VA - hh) / 2;
    if (hp >= xo && hp < xo + w && vp >= yo && vp < yo + hh) begin
      addr = (vp - yo) * w + (hp - xo);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
  endtask

  task automatic chk_reset();
    chk("rst_hs",     32'(vga_hs),         32'd1);
    chk("rst_vs",     32'(vga_vs),         32'd1);
    chk("rst_blank",  32'(vga_blank_n),    32'd0);
    chk("rst_rgb",    {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_fs",     32'(frame_start),    32'd0);
    chk("rst_rdaddr", 32'(ram_bus.rdaddr), 32'd0);
    chk("rst_sync_n", 32'(vga_sync_n),     32'd0);
  endtask

  task automatic check_cycle();
    int p, hp, vp, a;
    int e_hs, e_vs, e_bl;
    logic [7:0] e_rgb;
    if (t % FT == 0) begin
      g_w[t / FT]    = int'(img_w);
      g_h[t / FT]    = int'(img_h);
      g_show[t / FT] = fv && img_w >= 1 && img_w <= HA && img_h >= 1 && img_h <= VA;
      $display("frame %0d: w=%0d h=%0d valid=%0d show=%0d", t / FT, img_w, img_h, fv,
               g_show[t / FT]);
    end
    if (t >= 1 && win_at(t - 1, a)) exp_rd = 19'(a);
    e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = 8'h00;
    if (t >= 2) begin
      p  = t - 2;
      hp = p % HT;
      vp = (p / HT) % VT;
      e_hs = (hp >= HA + HFP && hp < HA + HFP + HSY) ? 0 : 1;
      e_vs = (vp >= VA + VFP && vp < VA + VFP + VSY) ? 0 : 1;
      e_bl = (hp < HA && vp < VA) ? 1 : 0;
      if (win_at(p, a)) e_rgb = ram_data(19'(a));
    end
    chk("hs",      32'(vga_hs),         32'(e_hs));
    chk("vs",      32'(vga_vs),         32'(e_vs));
    chk("blank_n", 32'(vga_blank_n),    32'(e_bl));
    chk("r",       32'(vga_r),          32'(e_rgb));
    chk("g",       32'(vga_g),          32'(e_rgb));
    chk("b",       32'(vga_b),          32'(e_rgb));
    chk("fs",      32'(frame_start),    32'(t % FT == 0));
    chk("rdaddr",  32'(ram_bus.rdaddr), 32'(exp_rd));
    chk("sync_n",  32'(vga_sync_n),     32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      t++;
      @(negedge clk);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    t      = 0;
    exp_rd = '0;
    #1;
  endtask

  initial begin
    int k;
    pass_cnt = 0; total_cnt = 0; t = 0; exp_rd = '0;
    rst_n = 1'b0; img_w = 10'd40; img_h = 9'd30; fv = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk_reset();
    end
    release_reset();

    // Full-size image, then a centred quarter, then an odd-border image.
    run(FT);
    img_w = 10'd20; img_h = 9'd15;
    run(FT);
    img_w = 10'd21; img_h = 9'd13;
    run(700);
    img_w = 10'd7; img_h = 9'd9; fv = 1'b0;
    run(FT - 700);
    // Frame latched invalid; validity rising mid-frame must wait a frame.
    run(500);
    fv = 1'b1;
    run(FT - 500);
    img_w = 10'd0;
    run(FT);
    img_w = 10'd45; img_h = 9'd20;
    run(FT);

    for (int r = 0; r < 4; r++) begin
      img_w = 10'($urandom_range(0, HA + 4));
      img_h = 9'($urandom_range(0, VA + 3));
      fv    = ($urandom_range(0, 3) != 0);
      k     = $urandom_range(1, FT - 1);
      run(k);
      img_w = 10'($urandom_range(1, HA));
      img_h = 9'($urandom_range(1, VA));
      fv    = $urandom_range(0, 1) != 0;
      run(FT - k);
    end

    // Asynchronous reset in the middle of the active area.
    img_w = 10'd30; img_h = 9'd20; fv = 1'b1;
    run(20 * HT + 30);
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (3) begin
      @(negedge clk); #1;
      chk_reset();
    end
    release_reset();
    run(FT + 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
